// File: rtl/psum_collector.sv
// Partial-sum collector: gathers skewed per-column PE streams into a DEPTH x COLS buffer,
// accumulating across K-tile passes with Q2.13 saturation, then drains it row by row.
module psum_collector #(
  parameter int unsigned COLS  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       I_CLK,
  input  logic                       I_RST,
  input  logic                       I_START,
  input  logic                       I_FIRST,
  input  logic                       I_LAST,
  input  logic [COLS-1:0]            I_D_VLD,
  input  logic [16*COLS-1:0]         I_D,
  output logic                       O_BUSY,
  output logic                       O_DONE,
  output logic                       O_VLD,
  input  logic                       I_RDY,
  output logic [16*COLS-1:0]         O_DATA,
  output logic [$clog2(DEPTH)-1:0]   O_ROW,
  output logic                       O_ERR
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RowW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e          state_q;
  logic            first_q, last_q, done_q, err_q;
  logic [RowW-1:0] rd_ptr_q;
  logic [CntW-1:0] wr_cnt_q [COLS];
  logic [15:0]     buf_q    [DEPTH][COLS];

  logic [CntW-1:0] wr_cnt_d [COLS];
  logic [15:0]     wr_val   [COLS];
  logic [COLS-1:0] wr_en;
  logic            all_full;
  logic            drop_err;
  logic            err_set;

  // Signed 17-bit sum clamped to the Q2.13 range.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    return s[15:0];
  endfunction

  always_comb begin
    all_full = 1'b1;
    drop_err = 1'b0;
    for (int unsigned c = 0; c < COLS; c++) begin
      wr_en[c]    = 1'b0;
      wr_val[c]   = '0;
      wr_cnt_d[c] = wr_cnt_q[c];
      if (state_q == StCollect && I_D_VLD[c]) begin
        if (wr_cnt_q[c] < CntW'(DEPTH)) begin
          wr_en[c]    = 1'b1;
          wr_cnt_d[c] = wr_cnt_q[c] + CntW'(1);
          wr_val[c]   = first_q ? I_D[16*c +: 16]
                                : sat_add(buf_q[wr_cnt_q[c][RowW-1:0]][c], I_D[16*c +: 16]);
        end else begin
          drop_err = 1'b1;
        end
      end
      if (wr_cnt_d[c] != CntW'(DEPTH)) all_full = 1'b0;
    end
  end

  always_comb begin
    err_set = 1'b0;
    unique case (state_q)
      StIdle:    err_set = |I_D_VLD;
      StCollect: err_set = I_START | drop_err;
      StDrain:   err_set = I_START | (|I_D_VLD);
      default:   err_set = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q  <= StIdle;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_ptr_q <= '0;
      for (int unsigned c = 0; c < COLS; c++) wr_cnt_q[c] <= '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        for (int unsigned c = 0; c < COLS; c++) buf_q[r][c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= err_q | err_set;
      unique case (state_q)
        StIdle: begin
          if (I_START) begin
            first_q <= I_FIRST;
            last_q  <= I_LAST;
            for (int unsigned c = 0; c < COLS; c++) wr_cnt_q[c] <= '0;
            state_q <= StCollect;
          end
        end
        StCollect: begin
          for (int unsigned c = 0; c < COLS; c++) begin
            wr_cnt_q[c] <= wr_cnt_d[c];
            if (wr_en[c]) buf_q[wr_cnt_q[c][RowW-1:0]][c] <= wr_val[c];
          end
          if (all_full) begin
            done_q   <= 1'b1;
            rd_ptr_q <= '0;
            state_q  <= last_q ? StDrain : StIdle;
          end
        end
        StDrain: begin
          if (I_RDY) begin
            if (rd_ptr_q == RowW'(DEPTH - 1)) begin
              rd_ptr_q <= '0;
              state_q  <= StIdle;
            end else begin
              rd_ptr_q <= rd_ptr_q + RowW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    O_BUSY = (state_q != StIdle);
    O_VLD  = (state_q == StDrain);
    O_DONE = done_q;
    O_ERR  = err_q;
    O_ROW  = O_VLD ? rd_ptr_q : '0;
    O_DATA = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (O_VLD) O_DATA[16*c +: 16] = buf_q[rd_ptr_q][c];
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: single/two-pass accumulation, saturation,
// backpressure, protocol errors and mid-pass reset.
module tb_psum_collector;
  localparam int COLS  = 4;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              I_RST, I_START, I_FIRST, I_LAST, I_RDY;
  logic [COLS-1:0]   I_D_VLD;
  logic [16*COLS-1:0] I_D;
  logic              O_BUSY, O_DONE, O_VLD, O_ERR;
  logic [16*COLS-1:0] O_DATA;
  logic [2:0]        O_ROW;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] pat  [COLS][DEPTH];
  logic [15:0] expv [DEPTH][COLS];

  always #5 clk = ~clk;

  psum_collector #(.COLS(COLS), .DEPTH(DEPTH)) dut (
    .I_CLK   (clk),
    .I_RST   (I_RST),
    .I_START (I_START),
    .I_FIRST (I_FIRST),
    .I_LAST  (I_LAST),
    .I_D_VLD (I_D_VLD),
    .I_D     (I_D),
    .O_BUSY  (O_BUSY),
    .O_DONE  (O_DONE),
    .O_VLD   (O_VLD),
    .I_RDY   (I_RDY),
    .O_DATA  (O_DATA),
    .O_ROW   (O_ROW),
    .O_ERR   (O_ERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] row_of(input int r);
    logic [63:0] v;
    for (int c = 0; c < COLS; c++) v[16*c +: 16] = expv[r][c];
    return v;
  endfunction

  task automatic fill(input int mode, input logic [15:0] base);
    // mode 0: constant; mode 1: base*(c+1)+r; mode 2: cols 0-1 base, cols 2-3 ~base+1
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (mode == 0) pat[c][r] = base;
        else if (mode == 1) pat[c][r] = base * 16'(c + 1) + 16'(r);
        else pat[c][r] = (c < 2) ? base : 16'hA000;
      end
    end
  endtask

  task automatic start_pass(input logic first, input logic last);
    chk("idle_before_start", {63'd0, O_BUSY}, 64'd0);
    I_START = 1'b1;
    I_FIRST = first;
    I_LAST  = last;
    step();
    I_START = 1'b0;
    chk("busy_after_start", {63'd0, O_BUSY}, 64'd1);
  endtask

  task automatic collect(input logic last, input logic inject);
    for (int k = 0; k < DEPTH + COLS - 1; k++) begin
      I_D_VLD = '0;
      I_D     = '0;
      I_START = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        if (k - c >= 0 && k - c < DEPTH) begin
          I_D_VLD[c]       = 1'b1;
          I_D[16*c +: 16]  = pat[c][k-c];
        end
      end
      if (inject && k == 2) begin
        I_START = 1'b1;
        I_FIRST = 1'b0;
        I_LAST  = 1'b0;
      end
      if (inject && k == DEPTH + COLS - 2) begin
        I_D_VLD[2]  = 1'b1;
        I_D[47:32]  = 16'h7777;
      end
      chk("collect_no_done", {63'd0, O_DONE}, 64'd0);
      chk("collect_no_vld", {63'd0, O_VLD}, 64'd0);
      step();
    end
    I_D_VLD = '0;
    I_D     = '0;
    I_START = 1'b0;
    chk("done_pulse", {63'd0, O_DONE}, 64'd1);
    chk("vld_after_done", {63'd0, O_VLD}, {63'd0, last});
    chk("busy_after_done", {63'd0, O_BUSY}, {63'd0, last});
  endtask

  task automatic drain(input logic bp, input logic inject);
    int row;
    int k;
    row = 0;
    k   = 0;
    while (row < DEPTH && k < 200) begin
      I_RDY = bp ? (k % 3 == 0) : 1'b1;
      if (inject && k == 1) begin
        I_D_VLD = '1;
        I_D     = {4{16'h1234}};
      end else begin
        I_D_VLD = '0;
        I_D     = '0;
      end
      chk("drain_vld", {63'd0, O_VLD}, 64'd1);
      chk("drain_row", {61'd0, O_ROW}, 64'(row));
      chk("drain_data", O_DATA, row_of(row));
      if (k > 0) chk("drain_no_done", {63'd0, O_DONE}, 64'd0);
      if (I_RDY) row++;
      step();
      k++;
    end
    I_RDY   = 1'b0;
    I_D_VLD = '0;
    I_D     = '0;
    chk("drain_rows", 64'(row), 64'(DEPTH));
    chk("idle_vld", {63'd0, O_VLD}, 64'd0);
    chk("idle_busy", {63'd0, O_BUSY}, 64'd0);
    chk("idle_data", O_DATA, 64'd0);
  endtask

  task automatic chk_reset_state;
    chk("rst_busy", {63'd0, O_BUSY}, 64'd0);
    chk("rst_done", {63'd0, O_DONE}, 64'd0);
    chk("rst_vld", {63'd0, O_VLD}, 64'd0);
    chk("rst_data", O_DATA, 64'd0);
    chk("rst_row", {61'd0, O_ROW}, 64'd0);
    chk("rst_err", {63'd0, O_ERR}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_RST   = 1'b1;
    I_START = 1'b0;
    I_FIRST = 1'b0;
    I_LAST  = 1'b0;
    I_RDY   = 1'b0;
    I_D_VLD = '0;
    I_D     = '0;
    @(negedge clk);
    step();
    chk_reset_state();
    I_RST = 1'b0;
    step();

    // Single overwrite+drain pass with skewed columns.
    fill(1, 16'h0100);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++) expv[r][c] = 16'h0100 * 16'(c + 1) + 16'(r);
    start_pass(1'b1, 1'b1);
    collect(1'b1, 1'b0);
    drain(1'b0, 1'b0);
    chk("single_err", {63'd0, O_ERR}, 64'd0);

    // Two passes of 1.0 accumulate to 2.0.
    fill(0, 16'h2000);
    start_pass(1'b1, 1'b0);
    collect(1'b0, 1'b0);
    step();
    start_pass(1'b0, 1'b1);
    collect(1'b1, 1'b0);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++) expv[r][c] = 16'h4000;
    drain(1'b0, 1'b0);

    // Saturation both directions, drained under backpressure.
    fill(2, 16'h6000);
    start_pass(1'b1, 1'b0);
    collect(1'b0, 1'b0);
    start_pass(1'b0, 1'b1);
    collect(1'b1, 1'b0);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++) expv[r][c] = (c < 2) ? 16'h7FFF : 16'h8000;
    drain(1'b1, 1'b0);
    chk("sat_err", {63'd0, O_ERR}, 64'd0);

    // Protocol errors: stray START, 9th valid on column 2, valid during drain.
    fill(1, 16'h0010);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++) expv[r][c] = 16'h0010 * 16'(c + 1) + 16'(r);
    start_pass(1'b1, 1'b1);
    collect(1'b1, 1'b1);
    chk("proto_err_set", {63'd0, O_ERR}, 64'd1);
    drain(1'b0, 1'b1);
    chk("proto_err_sticky", {63'd0, O_ERR}, 64'd1);

    // Reset in the middle of collection.
    start_pass(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      I_D_VLD = '1;
      I_D     = {4{16'h5555}};
      step();
    end
    I_D_VLD = '0;
    I_D     = '0;
    I_RST   = 1'b1;
    step();
    chk_reset_state();
    I_RST = 1'b0;
    step();
    fill(0, 16'h0001);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++) expv[r][c] = 16'h0001;
    start_pass(1'b1, 1'b1);
    collect(1'b1, 1'b0);
    drain(1'b0, 1'b0);
    chk("final_err", {63'd0, O_ERR}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
